full_adder_reg: RTL and testbench

//  Registered full-adder slice: adds a, b and carry-in cin, presents sum and carry-out one clock later.

---
 rtl/adder_pkg.sv | 5 +
 rtl/fa_cell.sv | 14 +
 rtl/full_adder_reg.sv | 52 +++++
 tb/tb_full_adder_reg.sv | 109 ++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: constants shared by the registered adder datapath.
//   FA_LATENCY : clock cycles from accepted operands to visible result.
package adder_pkg;
    localparam int FA_LATENCY = 1;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder, gate level.
//   a, b, cin : operand bits and carry in
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder_reg.sv
// full_adder_reg: WIDTH-bit ripple adder slice with one output register stage.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : a/b/cin valid this cycle
//   a, b, cin       : operands (b pre-inverted upstream for subtraction)
//   sum, cout       : registered (a + b + cin), sum mod 2**WIDTH and carry out
//   out_valid       : sum/cout hold a result accepted on the previous edge
module full_adder_reg
    import adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum_c[i]),
            .cout(carry[i+1])
        );
    end

    // Result registers only load on an accepted operand set, so anything
    // (including X) on the inputs while in_valid is low never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= sum_c;
            cout      <= carry[WIDTH];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_full_adder_reg.sv
module tb_full_adder_reg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v1 = 1'b0, v4 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0;
    logic       s1, co1, ov1;
    logic [3:0] s4;
    logic       co4, ov4;

    int n_chk  = 0;
    int n_fail = 0;

    // reference state, updated from the arithmetic rules after each edge
    int e_s1 = 0, e_c1 = 0, e_v1 = 0;
    int e_s4 = 0, e_c4 = 0, e_v4 = 0;

    always #5 clk = ~clk;

    full_adder_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .out_valid(ov1)
    );

    full_adder_reg #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
        .sum(s4), .cout(co4), .out_valid(ov4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance past the edge, update model, compare.
    task automatic step(input logic r,
                        input logic iv1, input int ia1, input int ib1, input int ic1,
                        input logic iv4, input int ia4, input int ib4, input int ic4);
        int full;
        rst = r;
        v1 = iv1; v4 = iv4;
        if (iv1) begin a1 = ia1[0]; b1 = ib1[0]; c1 = ic1[0]; end
        else     begin a1 = 1'bx;   b1 = 1'bx;   c1 = 1'bx;   end
        if (iv4) begin a4 = ia4[3:0]; b4 = ib4[3:0]; c4 = ic4[0]; end
        else     begin a4 = 'x;       b4 = 'x;       c4 = 1'bx;   end
        @(posedge clk);
        #1;
        if (r) begin
            e_s1 = 0; e_c1 = 0; e_v1 = 0;
            e_s4 = 0; e_c4 = 0; e_v4 = 0;
        end else begin
            if (iv1) begin
                full = (ia1 & 1) + (ib1 & 1) + (ic1 & 1);
                e_s1 = full % 2; e_c1 = full / 2; e_v1 = 1;
            end else e_v1 = 0;
            if (iv4) begin
                full = (ia4 & 15) + (ib4 & 15) + (ic4 & 1);
                e_s4 = full % 16; e_c4 = full / 16; e_v4 = 1;
            end else e_v4 = 0;
        end
        chk("w1_sum",  int'(s1),  e_s1);
        chk("w1_cout", int'(co1), e_c1);
        chk("w1_ov",   int'(ov1), e_v1);
        chk("w4_sum",  int'(s4),  e_s4);
        chk("w4_cout", int'(co4), e_c4);
        chk("w4_ov",   int'(ov4), e_v4);
    endtask

    initial begin
        // reset held with valid all-ones operands: outputs stay zero
        step(1, 1, 1, 1, 1, 1, 15, 15, 1);
        step(1, 1, 1, 1, 1, 1, 15, 15, 1);

        // WIDTH=1 exhaustive, WIDTH=4 random alongside
        for (int i = 0; i < 8; i++)
            step(0, 1, (i >> 2) & 1, (i >> 1) & 1, i & 1,
                 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));

        // WIDTH=4 directed: add, subtract form, wrap, then idle hold
        step(0, 1, 1, 1, 0, 1, 7, 3, 0);
        step(0, 1, 1, 1, 1, 1, 7, 3, 1);
        step(0, 1, 0, 1, 0, 1, 7, 12, 1);
        step(0, 1, 0, 0, 0, 1, 3, 8, 1);
        step(0, 1, 1, 1, 1, 1, 15, 15, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset mid-stream: 3 valid ops, rst on the 2nd
        step(0, 1, 1, 0, 1, 1, 9, 9, 0);
        step(1, 1, 1, 1, 1, 1, 5, 6, 1);
        step(0, 1, 0, 1, 1, 1, 4, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic with idle cycles and occasional reset
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
